buffer_unidad_param: RTL and testbench

Parametrised line-buffer unit for the filter architecture's row buffer: a single-clock FIFO with generic data width and depth, built from inferred storage rather than a fixed vendor core. It adds a programmable line length with a `line_ready` flag, an occupancy count, registered read data with a valid strobe, and sticky overflow/underflow error flags. Several instances are chained or selected by the row-buffer controller to match the image width.

---
 rtl/buffer_unidad_param.sv | 130 +++++++++++++
 tb/tb_buffer_unidad_param.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/buffer_unidad_param.sv
`default_nettype none
// ============================================================================
//  Module   : buffer_unidad_param
//  Purpose  : Parametrised single-clock line-buffer FIFO with occupancy count,
//             programmable line-length flag, registered read data with a
//             valid strobe, and sticky overflow/underflow flags.
//  Revision : 1.0 - initial release
// ============================================================================
module buffer_unidad_param #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 8,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclr,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write_req,
  input  logic                  read_req,
  input  logic [ADDR_WIDTH:0]   line_len,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic [ADDR_WIDTH:0]   usedw,
  output logic                  line_ready,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_usedw;
  logic [ADDR_WIDTH:0]   r_line_len;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_data_valid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_rd_ok;
  logic w_wr_ok;
  logic w_ovf_evt;
  logic w_udf_evt;

  // Status decode from registered occupancy; accept and error-event decode
  always_comb begin
    w_full    = (r_usedw == c_depth);
    w_empty   = (r_usedw == '0);
    // No write-to-read bypass: an empty FIFO rejects the read even with a
    // same-cycle write. A full FIFO accepts a write only alongside a read.
    w_rd_ok   = enable & read_req & ~w_empty;
    w_wr_ok   = enable & write_req & (~w_full | w_rd_ok);
    w_ovf_evt = enable & write_req & w_full & ~w_rd_ok;
    w_udf_evt = enable & read_req & w_empty;
  end

  // Storage array: not reset, written on every accepted write
  always_ff @(posedge clk) begin
    if (!sclr && w_wr_ok) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy, read data register and sticky error flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_usedw      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else if (sclr) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_usedw      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_ok) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_data_out <= r_mem[r_rd_ptr];
      end
      r_data_valid <= w_rd_ok;
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_usedw <= r_usedw + 1'b1;
        2'b01:   r_usedw <= r_usedw - 1'b1;
        default: r_usedw <= r_usedw;
      endcase
      if (w_ovf_evt) begin
        r_overflow <= 1'b1;
      end
      if (w_udf_evt) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Line length is sampled so a new value reaches the compare one cycle later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_line_len <= '0;
    end else begin
      r_line_len <= line_len;
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign usedw      = r_usedw;
  assign fifo_full  = w_full;
  assign fifo_empty = w_empty;
  assign line_ready = (r_line_len != '0) && (r_usedw >= r_line_len);
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_buffer_unidad_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_buffer_unidad_param
//  Purpose  : Scoreboard bench for buffer_unidad_param (DEPTH=8, 8-bit data).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_buffer_unidad_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       sclr;
  logic       enable;
  logic [7:0] data_in;
  logic       write_req;
  logic       read_req;
  logic [3:0] line_len;
  logic [7:0] data_out;
  logic       data_valid;
  logic       fifo_full;
  logic       fifo_empty;
  logic [3:0] usedw;
  logic       line_ready;
  logic       overflow;
  logic       underflow;

  buffer_unidad_param #(.DATA_WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .sclr(sclr), .enable(enable),
    .data_in(data_in), .write_req(write_req), .read_req(read_req),
    .line_len(line_len), .data_out(data_out), .data_valid(data_valid),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .usedw(usedw),
    .line_ready(line_ready), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] mq[$];     // reference FIFO contents
  logic [7:0] exp_q[$];  // expected read words, consumed by the monitor
  bit         m_ovf = 0;
  bit         m_udf = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    int ll = int'(line_len);
    chk({tag, " usedw"},      usedw,      mq.size());
    chk({tag, " full"},       fifo_full,  mq.size() == 8);
    chk({tag, " empty"},      fifo_empty, mq.size() == 0);
    chk({tag, " line_ready"}, line_ready, (ll != 0) && (mq.size() >= ll));
    chk({tag, " overflow"},   overflow,   m_ovf);
    chk({tag, " underflow"},  underflow,  m_udf);
  endtask

  // One clock of traffic; the reference model is updated with the same rules.
  task automatic op(input bit we, input bit re, input logic [7:0] d, input bit en);
    bit full, empty, rd_ok, wr_ok;
    enable = en; write_req = we; read_req = re; data_in = d;
    full  = (mq.size() == 8);
    empty = (mq.size() == 0);
    rd_ok = en && re && !empty;
    wr_ok = en && we && (!full || rd_ok);
    if (en && we && full && !rd_ok) m_ovf = 1;
    if (en && re && empty) m_udf = 1;
    if (rd_ok) exp_q.push_back(mq.pop_front());
    if (wr_ok) mq.push_back(d);
    @(posedge clk); #1;
    enable = 0; write_req = 0; read_req = 0;
    chk_state("op");
  endtask

  task automatic do_sclr(input bit with_req);
    sclr = 1; enable = with_req; write_req = with_req; read_req = with_req;
    data_in = 8'hEE;
    @(posedge clk); #1;
    sclr = 0; enable = 0; write_req = 0; read_req = 0;
    mq.delete(); m_ovf = 0; m_udf = 0;
    chk_state("sclr");
    chk("sclr data_valid", data_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 0; sclr = 0; enable = 0; data_in = 0;
    write_req = 0; read_req = 0; line_len = 4'd5;

    // Monitor: every data_valid pulse must match the oldest expected word
    fork
      forever begin
        @(negedge clk);
        if (data_valid) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL mon spurious data_valid: data_out 0x%0h, no read pending", data_out);
          end else begin
            chk("mon data_out", data_out, exp_q.pop_front());
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst data_out", data_out, 8'h00);
    chk("rst data_valid", data_valid, 0);
    chk_state("rst");
    reset = 1;
    @(posedge clk); #1;

    // Fill 0x10..0x17 with line_len=5
    for (int i = 0; i < 8; i++) begin
      op(1, 0, 8'h10 + 8'(i), 1);
      if (i == 3) chk("line_ready after 4", line_ready, 0);
      if (i == 4) chk("line_ready after 5", line_ready, 1);
    end
    chk("full usedw", usedw, 8);
    chk("full flag", fifo_full, 1);

    // Full: simultaneous read/write of 0xAA; read returns 0x10
    op(1, 1, 8'hAA, 1);
    chk("rw full usedw", usedw, 8);
    chk("rw full overflow", overflow, 0);

    // Write on full without read: rejected, overflow sticks
    op(1, 0, 8'hBB, 1);
    chk("ovf usedw", usedw, 8);
    chk("ovf flag", overflow, 1);

    // Enable gating: nothing changes
    for (int i = 0; i < 3; i++) op(1, 0, 8'h60 + 8'(i), 0);
    for (int i = 0; i < 2; i++) op(0, 1, 8'h00, 0);
    chk("gated data_out", data_out, 8'h10);
    chk("gated usedw", usedw, 8);

    // Drain: 0x11..0x17 then 0xAA
    for (int i = 0; i < 8; i++) op(0, 1, 8'h00, 1);
    @(negedge clk);
    chk("drain last word", data_out, 8'hAA);
    chk("drain empty", fifo_empty, 1);
    chk("overflow still set", overflow, 1);
    @(posedge clk); #1;

    // Read on empty: underflow, no data_valid
    op(0, 1, 8'h00, 1);
    chk("udf data_valid", data_valid, 0);
    chk("udf flag", underflow, 1);

    // Synchronous clear with a simultaneous request that must be dropped
    do_sclr(1);

    // line_len = 0: line_ready low at every fill level
    line_len = 4'd0;
    for (int i = 0; i < 8; i++) begin
      op(1, 0, 8'h30 + 8'(i), 1);
      chk("ll0 line_ready", line_ready, 0);
    end
    do_sclr(0);

    // Reset mid-operation at usedw = 5
    line_len = 4'd5;
    for (int i = 0; i < 5; i++) op(1, 0, 8'h40 + 8'(i), 1);
    chk("pre-reset usedw", usedw, 5);
    #2;
    reset = 0;
    #1;
    mq.delete(); m_ovf = 0; m_udf = 0;
    chk("async rst data_out", data_out, 8'h00);
    chk("async rst data_valid", data_valid, 0);
    chk_state("async rst");
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    op(1, 0, 8'h5C, 1);
    op(0, 1, 8'h00, 1);
    @(negedge clk);
    chk("post-reset read", data_out, 8'h5C);
    @(posedge clk); #1;

    chk("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
